// File: rtl/qadd_rr_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude fixed-point adder.
// Define QADD_RR_ARB_OVF_EN to add the saturating res_ovf output.
module qadd_rr_arbiter #(
  parameter int N    = 24,
  parameter int Q    = 14,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
`ifdef QADD_RR_ARB_OVF_EN
  output logic              res_ovf,
`endif
  input  logic              res_ready,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   a_q, b_q;
  logic [IDW-1:0] id_q;
  logic [N-1:0]   data_q, data_d;
  logic           ovf_d;
`ifdef QADD_RR_ARB_OVF_EN
  logic           ovf_q;
`endif

  logic           grant_en;
  logic           found;
  logic           hi_found;
  logic [IDW-1:0] hi_id, lo_id, gnt_id;
  logic           fire;

  assign grant_en = (state_q == IDLE) ||
                    ((state_q == OUT) && res_ready);

  // Lowest valid at/above the pointer wins, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    found    = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        lo_id = IDW'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    gnt_id = hi_found ? hi_id : lo_id;
  end

  assign fire = grant_en && found;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready = NREQ'(1) << gnt_id;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      if (int'(gnt_id) == NREQ - 1) ptr_d = '0;
      else ptr_d = gnt_id + IDW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (found) state_d = ADD;
      ADD:  state_d = OUT;
      OUT: begin
        if (res_ready) state_d = found ? ADD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic         sa, sb;
  logic [N-2:0] ma, mb;
  logic [N-1:0] msum;

  assign sa = a_q[N-1];
  assign sb = b_q[N-1];
  assign ma = a_q[N-2:0];
  assign mb = b_q[N-2:0];
  assign msum = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    data_d = '0;
    ovf_d  = 1'b0;
    if (sa == sb) begin
      data_d = {sa, msum[N-2:0]};
      ovf_d  = msum[N-1];
`ifdef QADD_RR_ARB_OVF_EN
      if (msum[N-1]) data_d = {sa, {(N-1){1'b1}}};
`endif
    end else if (ma > mb) begin
      data_d = {sa, ma - mb};
    end else if (mb > ma) begin
      data_d = {sb, mb - ma};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (fire) begin
        a_q  <= req_a[gnt_id*N +: N];
        b_q  <= req_b[gnt_id*N +: N];
        id_q <= gnt_id;
      end
      if (state_q == ADD) data_q <= data_d;
    end
  end

`ifdef QADD_RR_ARB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (state_q == ADD) ovf_q <= ovf_d;
  end
  assign res_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

  // res_id tracks the result owner, latched together with the sum.
  logic [IDW-1:0] rid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rid_q <= '0;
    else if (state_q == ADD) rid_q <= id_q;
  end

  assign res_valid = (state_q == OUT);
  assign res_data  = data_q;
  assign res_id    = rid_q;
  assign busy      = (state_q != IDLE);

endmodule
